// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions.
// Holds the opcode constants that main_decoder also uses, the nop encoding,
// and the state encoding of the instruction-fetch controller.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_VALID = 2'd2,
      ST_ERR   = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// pc_next: combinational next-PC selection for the fetch stage.
// Ports:
//   pc            in  32  current PC
//   branch_taken  in   1  select the redirect target
//   branch_target in  32  redirect address; bits [1:0] are dropped
//   pc_plus4      out 32  pc + 4, wrapping at 2^32
//   next_pc       out 32  aligned target when branch_taken, else pc + 4
module pc_next (
   input  logic [31:0] pc,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc
);

   // Low target bits are discarded; fetch addresses are always word aligned.
   logic unused_tgt_lsb;
   assign unused_tgt_lsb = ^branch_target[1:0];

   assign pc_plus4 = pc + 32'd4;
   assign next_pc  = branch_taken ? {branch_target[31:2], 2'b00} : pc_plus4;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC holder and instruction fetch controller feeding main_decoder.
// Requests words from instruction memory (ready-qualified), registers the
// returned word and holds it until the downstream stage consumes it. Branch
// redirects are taken only at the consume point.
// Optional feature macro: IMEM_TIMEOUT_EN (per-request wait-state limit,
// sticky fetch_timeout flag and terminal ERR state).
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   imem_req/imem_addr           fetch request and word address (= pc)
//   imem_ready/imem_rdata        memory response
//   stall                        downstream hold
//   branch_taken/branch_target   redirect at consume
//   instr/op/instr_valid         registered instruction, op field, qualifier
//   pc/pc_plus4                  address of instr and its successor
//   fetch_timeout                sticky timeout error
//
// state    | meaning
// ST_IDLE  | post-reset bubble, no request
// ST_REQ   | request outstanding at pc, waiting for imem_ready
// ST_VALID | instr holds a valid word, waiting for consume
// ST_ERR   | request timed out, parked until reset (IMEM_TIMEOUT_EN only)
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_timeout
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, instr_q, next_pc;
   logic         valid_q, load_instr, consume;

`ifdef IMEM_TIMEOUT_EN
   localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_q, set_timeout;
`else
   localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
`endif

   pc_next u_pc_next (
      .pc            (pc_q),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc_plus4      (pc_plus4),
      .next_pc       (next_pc)
   );

   always_comb begin
      state_d    = state_q;
      load_instr = 1'b0;
      consume    = 1'b0;
`ifdef IMEM_TIMEOUT_EN
      set_timeout = 1'b0;
`endif
      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (imem_ready) begin
               load_instr = 1'b1;
               state_d    = ST_VALID;
            end
`ifdef IMEM_TIMEOUT_EN
            // A response on the limit cycle wins over the timeout.
            else if (wait_cnt == TO_LAST) begin
               set_timeout = 1'b1;
               state_d     = ST_ERR;
            end
`endif
         end
         ST_VALID: begin
            if (!stall) begin
               consume = 1'b1;
               state_d = ST_REQ;
            end
         end
`ifdef IMEM_TIMEOUT_EN
         ST_ERR: state_d = ST_ERR;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= INSTR_NOP;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_instr) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
         end
         if (consume) begin
            pc_q    <= next_pc;
            valid_q <= 1'b0;
         end
      end
   end

`ifdef IMEM_TIMEOUT_EN
   // Outside REQ the count is held at zero, so every entry to REQ starts fresh.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q != ST_REQ)
            wait_cnt <= '0;
         else if (!imem_ready)
            wait_cnt <= wait_cnt + CNT_W'(1);
         if (set_timeout)
            timeout_q <= 1'b1;
      end
   end
   assign fetch_timeout = timeout_q;
`else
   assign fetch_timeout = 1'b0;
`endif

   assign imem_req    = (state_q == ST_REQ);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign op          = instr_q[31:26];
   assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] instr;
   logic [5:0]  op;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_timeout;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr         (instr),
      .op            (op),
      .instr_valid   (instr_valid),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .fetch_timeout (fetch_timeout)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } fetch_t;

   typedef struct {
      int          wait_cyc;
      logic [31:0] rdata;
      logic [5:0]  exp_op;
      int          stall_cyc;
      logic        br;
      logic [31:0] tgt;
   } vec_t;

   fetch_t      sb[$];
   vec_t        vecs[6];
   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] nxt_pc = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: record any handshake, advance, then check against the model.
   task automatic step();
      logic   prev_valid;
      fetch_t f;
      if (imem_req === 1'b1 && imem_ready === 1'b1) begin
         f.addr = imem_addr;
         f.data = imem_rdata;
         sb.push_back(f);
      end
      prev_valid = instr_valid;
      @(posedge clk);
      #1;
      exp_pc = nxt_pc;
      chk("pc", pc, exp_pc);
      chk("imem_addr", imem_addr, exp_pc);
      chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
      if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
         end else begin
            f = sb.pop_front();
            chk("sb_instr", instr, f.data);
            chk("sb_pc", pc, f.addr);
            chk("sb_op", {26'd0, op}, {26'd0, f.data[31:26]});
         end
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      sb.delete();
      exp_pc = 32'h0;
      nxt_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{3, 32'h2001_0005, OP_ADDI,  0, 1'b0, 32'h0000_0000};
      vecs[1] = '{0, 32'h1022_FFFE, OP_BEQ,   5, 1'b0, 32'h0000_0000};
      vecs[2] = '{1, 32'hAC43_0008, OP_SW,    0, 1'b1, 32'h0000_0103};
      vecs[3] = '{0, 32'h0000_0020, OP_RTYPE, 2, 1'b1, 32'hFFFF_FFFF};
      vecs[4] = '{2, 32'h8C01_0004, OP_LW,    0, 1'b0, 32'h0000_0000};
      vecs[5] = '{0, 32'h2002_0001, OP_ADDI,  1, 1'b1, 32'h0000_0040};

      imem_ready    = 1'b1;
      imem_rdata    = 32'h8C01_0004;
      stall         = 1'b1;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      do_reset();

      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, INSTR_NOP);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_timeout", {31'd0, fetch_timeout}, 32'd0);

      // First fetch with ready tied high: valid two edges after release.
      reset_n = 1'b1;
      step();
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_valid_early", {31'd0, instr_valid}, 32'd0);
      step();
      chk("first_valid", {31'd0, instr_valid}, 32'd1);
      chk("first_op", {26'd0, op}, {26'd0, OP_LW});
      stall      = 1'b0;
      imem_ready = 1'b0;
      nxt_pc     = 32'd4;
      step();
      stall = 1'b1;
      chk("first_consume_valid", {31'd0, instr_valid}, 32'd0);

      for (int v = 0; v < 6; v++) begin
         imem_ready = 1'b0;
         imem_rdata = 32'hFFFF_FFFF;
         for (int w = 0; w < vecs[v].wait_cyc; w++) begin
            // branch outside VALID must be ignored
            stall         = 1'b0;
            branch_taken  = 1'b1;
            branch_target = 32'h0000_5550;
            step();
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
         end
         branch_taken = 1'b0;
         stall        = 1'b1;
         imem_ready   = 1'b1;
         imem_rdata   = vecs[v].rdata;
         step();
         imem_ready = 1'b0;
         imem_rdata = 32'hFFFF_FFFF;
         chk("vec_valid", {31'd0, instr_valid}, 32'd1);
         chk("vec_op", {26'd0, op}, {26'd0, vecs[v].exp_op});
         chk("vec_req_low", {31'd0, imem_req}, 32'd0);
         for (int s = 0; s < vecs[v].stall_cyc; s++) begin
            stall         = 1'b1;
            branch_taken  = (s == 0);
            branch_target = 32'hDEAD_BEE0;
            step();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr, vecs[v].rdata);
         end
         stall         = 1'b0;
         branch_taken  = vecs[v].br;
         branch_target = vecs[v].tgt;
         nxt_pc = vecs[v].br ? {vecs[v].tgt[31:2], 2'b00} : exp_pc + 32'd4;
         step();
         branch_taken = 1'b0;
         stall        = 1'b1;
         chk("cons_valid", {31'd0, instr_valid}, 32'd0);
         chk("cons_req", {31'd0, imem_req}, 32'd1);
      end

      // Reset in the middle of an outstanding request.
      imem_ready = 1'b0;
      step();
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_pc", pc, 32'h0);
      chk("async_rst_req", {31'd0, imem_req}, 32'd0);
      sb.delete();
      exp_pc = 32'h0;
      nxt_pc = 32'h0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step();
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);
      imem_ready = 1'b1;
      imem_rdata = 32'h2001_0005;
      step();
      imem_ready = 1'b0;
      chk("post_rst_valid", {31'd0, instr_valid}, 32'd1);

      // Memory never answers.
      do_reset();
      reset_n = 1'b1;
      step();
`ifdef IMEM_TIMEOUT_EN
      repeat (3) step();
      chk("to_not_yet", {31'd0, fetch_timeout}, 32'd0);
      chk("to_req_still", {31'd0, imem_req}, 32'd1);
      step();
      chk("to_flag", {31'd0, fetch_timeout}, 32'd1);
      chk("to_req_drop", {31'd0, imem_req}, 32'd0);
      repeat (2) step();
      chk("to_sticky", {31'd0, fetch_timeout}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("to_async_clr", {31'd0, fetch_timeout}, 32'd0);
      chk("to_async_req", {31'd0, imem_req}, 32'd0);
`else
      repeat (20) step();
      chk("nto_req", {31'd0, imem_req}, 32'd1);
      chk("nto_flag", {31'd0, fetch_timeout}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
